lmsm_sequencer: RTL and testbench
=================================

# lmsm_sequencer

Parametrised load-multiple / store-multiple transfer sequencer for the multi-cycle RISC core, sitting between the controller and the datapath's register file and memory port. On a start command it walks a register mask from lowest to highest set bit and moves each selected register to or from consecutive memory words starting at a base address. Register count, data and address widths are parameters. It adds three features to the core's fixed 8-register LM/SM flow: a memory ready handshake (wait states), an empty-mask fast path, and a transfer counter.

## Interface
- DATA_W, 16, register and memory word width
- ADDR_W, 16, memory address width
- NREG, 8, number of architectural registers (mask width); IDX_W = $clog2(NREG), CNT_W = $clog2(NREG+1) derived

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = LM (memory→regs), 1 = SM (regs→memory)
- reg_mask  in  NREG  bit i set = transfer register i
- base_addr  in  ADDR_W  address of first transferred word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier (SM)
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  access completes in the cycle mem_req && mem_ready
- mem_rdata  in  DATA_W  load data, valid with mem_ready
- rf_raddr  out  IDX_W  register read index (SM); rf_rdata returns combinationally
- rf_rdata  in  DATA_W  register read data
- rf_we  out  1  register write enable (LM)
- rf_waddr  out  IDX_W  register write index
- rf_wdata  out  DATA_W  register write data
- xfer_count  out  CNT_W  transfers completed in the current/last command

## Operation
- States: IDLE, ACCESS, WB, DONE.
- IDLE: start=1 latches mode, reg_mask (as remaining mask), base_addr; clears xfer_count and offset k. Remaining mask nonzero → ACCESS; zero → DONE (no memory access).
- Current index idx = lowest set bit of remaining mask.
- ACCESS: mem_req=1, mem_addr = base + k (mod 2^ADDR_W, wraps silently), mem_we = mode. SM: rf_raddr = idx, mem_wdata = rf_rdata. Outputs held stable until handshake.
- On handshake: clear bit idx, k+1, xfer_count+1. LM: capture mem_rdata and idx → WB. SM: more bits remain → ACCESS, else → DONE.
- WB (LM only): rf_we=1, rf_waddr = captured idx, rf_wdata = captured data; then more bits → ACCESS, else → DONE.
- DONE: done=1 for exactly one cycle → IDLE. xfer_count holds until next accepted start.
- start while busy is ignored; mask/mode/base inputs are don't-care after acceptance.
- Reset value of every output 0; state IDLE. Reset mid-transfer aborts immediately: mem_req, rf_we and done are 0 in the cycle after reset, no partial write-back occurs.
- mem_we, mem_wdata, rf_raddr are 0 whenever mem_req=0; rf_waddr/rf_wdata are 0 whenever rf_we=0.

## Timing
- start accepted at cycle 0 → first mem_req at cycle 1.
- SM, mem_ready tied high: one cycle per register; done at cycle N+1 for N set bits.
- LM, mem_ready tied high: two cycles per register (ACCESS, WB); done at cycle 2N+1.
- Each wait cycle (mem_ready=0) extends ACCESS by one cycle, no other effect.
- Empty mask: done at cycle 1, busy high only in cycle 1, xfer_count=0.
- Back-to-back: start can be accepted in the cycle after done (IDLE).

## Test plan
- SM, mask=0b0000_0101, base=0x0100, ready=1 → cycle1 addr 0x0100 wdata=R0, cycle2 addr 0x0101 wdata=R2, done at cycle3, xfer_count=2.
- LM, mask=0b1000_0010, base=0x0040, mem returns 0xAAAA/0x5555 → rf writes R1=0xAAAA (cycle2), R7=0x5555 (cycle4), done cycle5, xfer_count=2.
- Empty mask, either mode → no mem_req, done at cycle1, xfer_count=0.
- SM mask=0xFF, base=0xFFFE, mem_ready low two cycles on 2nd access → addresses 0xFFFE,0xFFFF,0x0000..0x0005, addr/data stable during wait, done at cycle 11.
- Reset asserted during LM WB of 2nd register → next cycle all outputs 0, only 1st register written, later start runs normally.
- start pulsed while busy → ignored; command completes unchanged, single done pulse.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: load-multiple / store-multiple transfer sequencer.
// Walks a register mask low->high against consecutive memory words.
module lmsm_sequencer #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 16,
    parameter  int NREG   = 8,
    localparam int IDX_W  = $clog2(NREG),
    localparam int CNT_W  = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WB,
        DONE
    } state_t;

    state_t            state;
    logic              mode_r;
    logic [NREG-1:0]   mask_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] k_r;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx;
    logic [NREG-1:0]   mask_next;
    logic              is_acc;
    logic              is_sm_acc;

    // Current register is the lowest set bit of the remaining mask
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_r[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit yields the mask after this transfer
    assign mask_next = mask_r & (mask_r - NREG'(1));

    // Command latch, mask walk, offset/count tracking and state sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            mask_r  <= '0;
            base_r  <= '0;
            k_r     <= '0;
            wb_idx  <= '0;
            wb_data <= '0;
            cnt_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        mask_r <= reg_mask;
                        base_r <= base_addr;
                        k_r    <= '0;
                        cnt_r  <= '0;
                        state  <= (reg_mask != '0) ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mask_r <= mask_next;
                        k_r    <= k_r + ADDR_W'(1);
                        cnt_r  <= cnt_r + CNT_W'(1);
                        if (!mode_r) begin
                            wb_idx  <= idx;
                            wb_data <= mem_rdata;
                            state   <= WB;
                        end else begin
                            state <= (mask_next != '0) ? ACCESS : DONE;
                        end
                    end
                end
                WB: begin
                    state <= (mask_r != '0) ? ACCESS : DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign is_acc    = (state == ACCESS);
    assign is_sm_acc = is_acc && mode_r;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign xfer_count = cnt_r;

    assign mem_req   = is_acc;
    assign mem_we    = is_sm_acc;
    assign mem_addr  = is_acc ? (base_r + k_r) : '0;
    assign rf_raddr  = is_sm_acc ? idx : '0;
    assign mem_wdata = is_sm_acc ? rf_rdata : '0;

    // A reset landing on a write-back cycle must not commit that write
    assign rf_we    = (state == WB) && !reset;
    assign rf_waddr = rf_we ? wb_idx : '0;
    assign rf_wdata = rf_we ? wb_data : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: table, hand-written and random checks of
// lmsm_sequencer against a queue-based transfer model.
module tb_lmsm_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  xfer_count;

    logic [15:0] tb_rf [8];
    logic [15:0] tb_mem [65536];

    int checks;
    int errors;

    lmsm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .reg_mask   (reg_mask),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .xfer_count (xfer_count)
    );

    assign rf_rdata = tb_rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          md;
        logic [7:0]  mk;
        logic [15:0] bs;
        int          pct;
        int          stall_acc;
        int          stall_len;
        int          exp_n;
        int          exp_done;
        bit          stray;
    } vec_t;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {busy, done, mem_req, mem_we, mem_addr, mem_wdata,
                rf_raddr, rf_we, rf_waddr, rf_wdata, xfer_count};
    endfunction

    // Run one command; called just after a falling edge.
    task automatic run_cmd(input bit md, input logic [7:0] mk,
                           input logic [15:0] bs, input int pct,
                           input int stall_acc, input int stall_len,
                           input int exp_n, input int exp_done,
                           input bit stray);
        logic [15:0] ea [$];
        logic [2:0]  ei [$];
        logic [15:0] ed [$];
        int  acc;
        int  wr;
        int  rw;
        int  stall_left;
        int  k;
        bit  fin;
        bit  rdy;
        acc = 0;
        wr = 0;
        rw = 0;
        k = 0;
        fin = 0;
        stall_left = stall_len;
        for (int i = 0; i < 8; i++) begin
            if (mk[i]) begin
                ei.push_back(3'(i));
                ea.push_back(bs + 16'(k));
                k++;
            end
        end
        mode = md;
        reg_mask = mk;
        base_addr = bs;
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            mode = 1'($urandom);
            reg_mask = 8'($urandom);
            base_addr = 16'($urandom);
            chk("busy", busy, 1);
            chk("xfer_count_run", xfer_count, acc);
            if (mem_req) begin
                if (acc >= ea.size()) begin
                    chk("extra_access", acc, ea.size());
                    break;
                end
                chk("mem_addr", mem_addr, ea[acc]);
                chk("mem_we", mem_we, md);
                if (md) begin
                    chk("rf_raddr", rf_raddr, ei[acc]);
                    chk("mem_wdata", mem_wdata, tb_rf[ei[acc]]);
                end
            end else begin
                chk("idle_mem_zero", {mem_we, mem_wdata, rf_raddr}, 0);
            end
            if (rf_we) begin
                if (md || wr >= ed.size()) begin
                    chk("extra_rf_we", wr, ed.size());
                    break;
                end
                chk("rf_waddr", rf_waddr, ei[wr]);
                chk("rf_wdata", rf_wdata, ed[wr]);
                tb_rf[rf_waddr] = rf_wdata;
                wr++;
            end else begin
                chk("idle_rf_zero", {rf_waddr, rf_wdata}, 0);
            end
            if (done) begin
                chk("done_cycle", c, exp_done + rw);
                chk("accesses", acc, exp_n);
                chk("writebacks", wr, md ? 0 : exp_n);
                fin = 1;
                break;
            end
            if (mem_req) begin
                if (acc == stall_acc && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (int'($urandom_range(99)) >= pct) begin
                    rdy = 1'b0;
                    rw++;
                end else begin
                    rdy = 1'b1;
                end
            end else begin
                rdy = 1'($urandom);
            end
            mem_ready = rdy;
            if (mem_req && rdy) begin
                mem_rdata = tb_mem[mem_addr];
                if (md) tb_mem[mem_addr] = mem_wdata;
                else ed.push_back(tb_mem[mem_addr]);
                acc++;
            end else begin
                mem_rdata = 16'($urandom);
            end
            if (stray && $urandom_range(3) == 0) start = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", fin, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_after", busy, 0);
        chk("xfer_count_hold", xfer_count, exp_n);
        chk("no_req_after", mem_req, 0);
    endtask

    vec_t vecs [8];

    initial begin
        logic [15:0] r2_old;
        logic [7:0]  mk;
        bit          md;
        int          n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        reg_mask = '0;
        base_addr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) tb_mem[i] = 16'(i) ^ 16'h5A3C;
        for (int i = 0; i < 8; i++) tb_rf[i] = 16'($urandom);
        tb_mem[16'h0040] = 16'hAAAA;
        tb_mem[16'h0041] = 16'h5555;

        vecs[0] = '{1, 8'h05, 16'h0100, 100, -1, 0, 2, 3, 0};
        vecs[1] = '{0, 8'h82, 16'h0040, 100, -1, 0, 2, 5, 0};
        vecs[2] = '{1, 8'h00, 16'h1234, 100, -1, 0, 0, 1, 0};
        vecs[3] = '{0, 8'h00, 16'h4321, 100, -1, 0, 0, 1, 0};
        vecs[4] = '{1, 8'hFF, 16'hFFFE, 100, 1, 2, 8, 11, 0};
        vecs[5] = '{0, 8'h06, 16'h0200, 100, -1, 0, 2, 5, 1};
        vecs[6] = '{0, 8'hFF, 16'hFFFC, 100, -1, 0, 8, 17, 0};
        vecs[7] = '{1, 8'h80, 16'h0010, 100, -1, 0, 1, 2, 1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_out(), 0);

        for (int v = 0; v < 8; v++) begin
            run_cmd(vecs[v].md, vecs[v].mk, vecs[v].bs, vecs[v].pct,
                    vecs[v].stall_acc, vecs[v].stall_len,
                    vecs[v].exp_n, vecs[v].exp_done, vecs[v].stray);
            if (v == 1) begin
                chk("lm_r1", tb_rf[1], 16'hAAAA);
                chk("lm_r7", tb_rf[7], 16'h5555);
            end
        end

        r2_old = tb_rf[2];
        mode = 1'b0;
        reg_mask = 8'h06;
        base_addr = 16'h0300;
        mem_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_rdata = tb_mem[mem_addr];
            if (c == 1 || c == 3) chk("rst_seq_req", mem_req, 1);
            if (c == 2) begin
                chk("rst_seq_wb1", {rf_we, rf_waddr}, {1'b1, 3'd1});
                tb_rf[rf_waddr] = rf_wdata;
            end
            if (c == 4) begin
                chk("rst_seq_wb2", {rf_we, rf_waddr}, {1'b1, 3'd2});
                reset = 1'b1;
                #1;
                chk("rst_abort_we", rf_we, 0);
                if (rf_we) tb_rf[rf_waddr] = rf_wdata;
            end
        end
        @(negedge clk);
        chk("rst_mid_outputs", all_out(), 0);
        reset = 1'b0;
        chk("rst_r1", tb_rf[1], tb_mem[16'h0300]);
        chk("rst_r2", tb_rf[2], r2_old);
        @(negedge clk);
        chk("rst_idle", all_out(), 0);

        for (int t = 0; t < 40; t++) begin
            md = 1'($urandom);
            mk = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            n = $countones(mk);
            run_cmd(md, mk, 16'($urandom), int'($urandom_range(100, 50)),
                    -1, 0, n, 1 + n * (md ? 1 : 2), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
